// File: rtl/adf4351_pkg.sv
// adf4351_pkg: shared widths, register addresses and lock FSM encoding
package adf4351_pkg;
   localparam int ADF_WORD_W   = 32;
   localparam int ADF_NUM_REGS = 6;
   localparam int ADF_CTRL_W   = 3;

   localparam logic [ADF_CTRL_W-1:0] ADF_R0 = 3'd0;
   localparam logic [ADF_CTRL_W-1:0] ADF_R1 = 3'd1;
   localparam logic [ADF_CTRL_W-1:0] ADF_R2 = 3'd2;
   localparam logic [ADF_CTRL_W-1:0] ADF_R3 = 3'd3;
   localparam logic [ADF_CTRL_W-1:0] ADF_R4 = 3'd4;
   localparam logic [ADF_CTRL_W-1:0] ADF_R5 = 3'd5;

   typedef enum logic [1:0] {
      LK_UNLOCKED = 2'd0,
      LK_COUNTING = 2'd1,
      LK_LOCKED   = 2'd2
   } lock_state_t;

   // Reset image of register n: all zero, or the address in the control bits
   function automatic logic [ADF_WORD_W-1:0] adf_rst_val(input int n, input bit rst_zero);
      return rst_zero ? '0 : ADF_WORD_W'(n);
   endfunction
endpackage

// File: rtl/adf_sync_edge.sv
// adf_sync_edge: 2-FF synchronizer with rising-edge detect for one async input
module adf_sync_edge
   import adf4351_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic lvl,
   output logic rise
);
   // [0],[1] are the synchronizer stages, [2] is the delayed copy for edge detect
   logic [2:0] pipe_q, pipe_d;

   // next pipeline contents: shift the raw input in
   always_comb pipe_d = {pipe_q[1:0], din};

   // pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign lvl  = pipe_q[1];
   assign rise = pipe_q[1] & ~pipe_q[2];
endmodule

// File: rtl/adf4351_spi_model.sv
// adf4351_spi_model: ADF4351 3-wire serial receiver, register file and lock-detect model
module adf4351_spi_model
   import adf4351_pkg::*;
#(
   parameter int LOCK_CYCLES = 5000,
   parameter bit RST_ZERO    = 1'b0
) (
   input  logic                  clk_50,
   input  logic                  rst_n,
   input  logic                  vco_clk,
   input  logic                  vco_data,
   input  logic                  vco_le,
   input  logic                  vco_ce,
   output logic                  vco_ld,
   output logic [ADF_WORD_W-1:0] reg0,
   output logic [ADF_WORD_W-1:0] reg1,
   output logic [ADF_WORD_W-1:0] reg2,
   output logic [ADF_WORD_W-1:0] reg3,
   output logic [ADF_WORD_W-1:0] reg4,
   output logic [ADF_WORD_W-1:0] reg5,
   output logic                  wr_stb,
   output logic [ADF_CTRL_W-1:0] wr_addr,
   output logic                  frame_err
);
   localparam int               CNT_W     = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] LK_LAST   = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [5:0]       BITS_FULL = 6'd32;
   localparam logic [5:0]       BITS_SAT  = 6'd33;

   logic clk_rise, le_s, le_rise, data_s, ce_s;
   logic clk_lvl_unused, data_rise_unused, ce_rise_unused;

   logic [ADF_WORD_W-1:0] shreg_q, shreg_d;
   logic [5:0]            bit_cnt_q, bit_cnt_d;
   logic [ADF_WORD_W-1:0] regs_q [ADF_NUM_REGS];
   logic [ADF_WORD_W-1:0] regs_d [ADF_NUM_REGS];
   logic                  wr_stb_q, wr_stb_d, frame_err_q, frame_err_d, r0_seen_q, r0_seen_d;
   logic [ADF_CTRL_W-1:0] wr_addr_q, wr_addr_d;
   lock_state_t           lk_state_q, lk_state_d;
   logic [CNT_W-1:0]      lk_cnt_q, lk_cnt_d;

   logic [ADF_CTRL_W-1:0] addr;
   logic                  commit_ok, lock_hit;

   adf_sync_edge u_clk  (.clk(clk_50), .rst_n(rst_n), .din(vco_clk),  .lvl(clk_lvl_unused), .rise(clk_rise));
   adf_sync_edge u_data (.clk(clk_50), .rst_n(rst_n), .din(vco_data), .lvl(data_s),         .rise(data_rise_unused));
   adf_sync_edge u_le   (.clk(clk_50), .rst_n(rst_n), .din(vco_le),   .lvl(le_s),           .rise(le_rise));
   adf_sync_edge u_ce   (.clk(clk_50), .rst_n(rst_n), .din(vco_ce),   .lvl(ce_s),           .rise(ce_rise_unused));

   assign addr      = shreg_q[ADF_CTRL_W-1:0];
   assign commit_ok = le_rise && bit_cnt_q == BITS_FULL && addr <= ADF_R5;
   assign lock_hit  = commit_ok && (addr == ADF_R0 || addr == ADF_R1 || addr == ADF_R4);

   // shift on serial clock, commit or flag error on LE rise; LE rise masks a coincident clock edge
   always_comb begin
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      regs_d      = regs_q;
      wr_stb_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      frame_err_d = 1'b0;
      r0_seen_d   = r0_seen_q;
      if (le_rise) begin
         bit_cnt_d   = '0;
         frame_err_d = !commit_ok;
         if (commit_ok) begin
            regs_d[addr] = shreg_q;
            wr_stb_d     = 1'b1;
            wr_addr_d    = addr;
            r0_seen_d    = r0_seen_q | (addr == ADF_R0);
         end
      end else if (clk_rise && !le_s) begin
         shreg_d   = {shreg_q[ADF_WORD_W-2:0], data_s};
         bit_cnt_d = (bit_cnt_q == BITS_SAT) ? BITS_SAT : bit_cnt_q + 6'd1;
      end
   end

   // lock FSM: power-down beats a lock-affecting commit, which beats normal progress
   always_comb begin
      lk_state_d = lk_state_q;
      lk_cnt_d   = lk_cnt_q;
      if (!ce_s) begin
         lk_state_d = LK_UNLOCKED;
         lk_cnt_d   = '0;
      end else if (lock_hit) begin
         lk_state_d = LK_COUNTING;
         lk_cnt_d   = '0;
      end else begin
         case (lk_state_q)
            LK_UNLOCKED: if (r0_seen_q) begin
               lk_state_d = LK_COUNTING;
               lk_cnt_d   = '0;
            end
            LK_COUNTING: if (lk_cnt_q == LK_LAST) lk_state_d = LK_LOCKED;
                         else lk_cnt_d = lk_cnt_q + CNT_W'(1);
            LK_LOCKED:   lk_state_d = LK_LOCKED;
            default:     lk_state_d = LK_UNLOCKED;
         endcase
      end
   end

   // state registers
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         for (int i = 0; i < ADF_NUM_REGS; i++) regs_q[i] <= adf_rst_val(i, RST_ZERO);
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
         r0_seen_q   <= 1'b0;
         lk_state_q  <= LK_UNLOCKED;
         lk_cnt_q    <= '0;
      end else begin
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         regs_q      <= regs_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         frame_err_q <= frame_err_d;
         r0_seen_q   <= r0_seen_d;
         lk_state_q  <= lk_state_d;
         lk_cnt_q    <= lk_cnt_d;
      end
   end

   assign vco_ld    = (lk_state_q == LK_LOCKED);
   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign frame_err = frame_err_q;
   assign reg0      = regs_q[0];
   assign reg1      = regs_q[1];
   assign reg2      = regs_q[2];
   assign reg3      = regs_q[3];
   assign reg4      = regs_q[4];
   assign reg5      = regs_q[5];
endmodule

// File: tb/tb_adf4351_spi_model.sv
// tb_adf4351_spi_model: randomized self-checking bench against a frame-level register/lock model
module tb_adf4351_spi_model;
   localparam int L = 5000;

   logic clk_50 = 1'b0, rst_n = 1'b0, vco_clk = 1'b0, vco_data = 1'b0, vco_le = 1'b0, vco_ce = 1'b0;
   logic vco_ld, wr_stb, frame_err;
   logic [2:0]  wr_addr;
   logic [31:0] reg0, reg1, reg2, reg3, reg4, reg5;
   logic [31:0] dut_regs [6];
   logic [31:0] exp_regs [6];

   int pass_cnt = 0, total = 0;
   int cyc = 0, stb_cyc = -1, ld_rise_cyc = -1, ld_fall_cyc = -1, fe_cnt = 0;
   logic [2:0] stb_q [$];

   always #10 clk_50 = ~clk_50;

   adf4351_spi_model #(.LOCK_CYCLES(L), .RST_ZERO(1'b0)) dut (
      .clk_50(clk_50), .rst_n(rst_n), .vco_clk(vco_clk), .vco_data(vco_data),
      .vco_le(vco_le), .vco_ce(vco_ce), .vco_ld(vco_ld),
      .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
      .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
   );

   assign dut_regs[0] = reg0;
   assign dut_regs[1] = reg1;
   assign dut_regs[2] = reg2;
   assign dut_regs[3] = reg3;
   assign dut_regs[4] = reg4;
   assign dut_regs[5] = reg5;

   // event recorder: strobe addresses, error pulses and lock transitions with their cycle numbers
   initial begin
      logic ld_prev;
      ld_prev = 1'b0;
      forever begin
         @(negedge clk_50);
         cyc++;
         if (wr_stb === 1'b1) begin
            stb_q.push_back(wr_addr);
            stb_cyc = cyc;
         end
         if (frame_err === 1'b1) fe_cnt++;
         if (vco_ld === 1'b1 && !ld_prev) ld_rise_cyc = cyc;
         if (vco_ld === 1'b0 && ld_prev) ld_fall_cyc = cyc;
         ld_prev = (vco_ld === 1'b1);
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   // send the low n bits of w MSB first with randomized legal bit timing, optionally pulse LE
   task automatic send(input logic [63:0] w, input int n, input bit do_le);
      int h;
      for (int i = n - 1; i >= 0; i--) begin
         h = $urandom_range(3, 5);
         vco_data = w[i];
         vco_clk  = 1'b0;
         tick(h);
         vco_clk  = 1'b1;
         tick(h);
      end
      vco_clk = 1'b0;
      tick(3);
      if (do_le) begin
         vco_le = 1'b1;
         tick(4);
         vco_le = 1'b0;
         tick(4);
      end
   endtask

   // frame-level model: only an exact 32-bit word with address 0..5 writes a register
   function automatic bit model_ok(input logic [63:0] w, input int n);
      return n == 32 && w[2:0] < 3'd6;
   endfunction

   task automatic model_commit(input logic [63:0] w, input int n);
      if (model_ok(w, n)) exp_regs[w[2:0]] = w[31:0];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) exp_regs[i] = 32'(i);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      vco_ce = 1'b1;
      model_reset();
      tick(3);
      for (int i = 0; i < 6; i++) begin
         total++;
         if (dut_regs[i] !== exp_regs[i]) $display("FAIL reset_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]);
         else pass_cnt++;
      end
      total++;
      if ({vco_ld, wr_stb, frame_err, wr_addr} !== 6'b0) $display("FAIL reset_outputs: got ld=%b stb=%b fe=%b addr=%0d expected all 0", vco_ld, wr_stb, frame_err, wr_addr);
      else pass_cnt++;
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_single_write();
      int fe0;
      fe0 = fe_cnt;
      stb_q.delete();
      send(64'h0058_0005, 32, 1'b1);
      model_commit(64'h0058_0005, 32);
      tick(2);
      total++;
      if (stb_q.size() != 1 || stb_q[0] !== 3'd5) $display("FAIL single_stb: got %0d pulses first addr %0d expected 1 pulse addr 5", stb_q.size(), stb_q.size() ? stb_q[0] : 3'd0);
      else pass_cnt++;
      total++;
      if (fe_cnt != fe0 || vco_ld !== 1'b0) $display("FAIL single_fe_ld: got fe_pulses=%0d ld=%b expected 0 and 0", fe_cnt - fe0, vco_ld);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (dut_regs[i] !== exp_regs[i]) $display("FAIL single_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_lock();
      int k;
      ld_rise_cyc = -1;
      send(64'h0035_8000, 32, 1'b1);
      model_commit(64'h0035_8000, 32);
      k = 0;
      while (vco_ld !== 1'b1 && k < L + 50) begin tick(1); k++; end
      tick(1);
      total++;
      if (ld_rise_cyc - stb_cyc != L) $display("FAIL lock_r0_delay: got %0d cycles expected %0d", ld_rise_cyc - stb_cyc, L);
      else pass_cnt++;
      ld_fall_cyc = -1;
      send(64'h0000_4E42, 32, 1'b1);
      model_commit(64'h0000_4E42, 32);
      tick(2);
      total++;
      if (vco_ld !== 1'b1 || ld_fall_cyc != -1) $display("FAIL lock_r2_keeps: got ld=%b fall_cyc=%0d expected ld=1 no fall", vco_ld, ld_fall_cyc);
      else pass_cnt++;
      total++;
      if (reg2 !== exp_regs[2]) $display("FAIL lock_r2_reg: got %h expected %h", reg2, exp_regs[2]);
      else pass_cnt++;
      ld_rise_cyc = -1;
      send(64'h0800_8011, 32, 1'b1);
      model_commit(64'h0800_8011, 32);
      total++;
      if (ld_fall_cyc != stb_cyc) $display("FAIL lock_r1_drop: got fall at %0d expected %0d", ld_fall_cyc, stb_cyc);
      else pass_cnt++;
      k = 0;
      while (vco_ld !== 1'b1 && k < L + 50) begin tick(1); k++; end
      tick(1);
      total++;
      if (ld_rise_cyc - stb_cyc != L) $display("FAIL lock_r1_delay: got %0d cycles expected %0d", ld_rise_cyc - stb_cyc, L);
      else pass_cnt++;
   endtask

   task automatic test_frame_err();
      logic [63:0] w [3];
      int n [3];
      int fe0;
      w[0] = 64'h1234_5670; n[0] = 31;
      w[1] = 64'hAB_CDEF_0123_4561; n[1] = 40;
      w[2] = 64'h0000_0006; n[2] = 32;
      for (int f = 0; f < 3; f++) begin
         fe0 = fe_cnt;
         stb_q.delete();
         send(w[f], n[f], 1'b1);
         model_commit(w[f], n[f]);
         tick(2);
         total++;
         if (fe_cnt - fe0 != 1 || stb_q.size() != 0) $display("FAIL frame_err%0d: got fe_pulses=%0d stb=%0d expected 1 and 0", f, fe_cnt - fe0, stb_q.size());
         else pass_cnt++;
      end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (dut_regs[i] !== exp_regs[i]) $display("FAIL frame_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_power_down();
      int k;
      vco_ce = 1'b0;
      k = 0;
      while (vco_ld !== 1'b0 && k < 10) begin tick(1); k++; end
      total++;
      if (vco_ld !== 1'b0 || k > 3) $display("FAIL pd_ld_drop: got ld=%b after %0d cycles expected 0 within 3", vco_ld, k);
      else pass_cnt++;
      send(64'h0000_04B3, 32, 1'b1);
      model_commit(64'h0000_04B3, 32);
      total++;
      if (reg3 !== exp_regs[3] || vco_ld !== 1'b0) $display("FAIL pd_r3: got reg3=%h ld=%b expected %h and 0", reg3, vco_ld, exp_regs[3]);
      else pass_cnt++;
      vco_ce = 1'b1;
      k = 0;
      while (vco_ld !== 1'b1 && k < L + 50) begin tick(1); k++; end
      total++;
      if (k != L + 3) $display("FAIL pd_relock: got %0d cycles expected %0d (LOCK_CYCLES plus 3 cycles of input sync)", k, L + 3);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      send(64'hFFFF, 16, 1'b0);
      #5 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         total++;
         if (dut_regs[i] !== exp_regs[i]) $display("FAIL midrst_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]);
         else pass_cnt++;
      end
      total++;
      if (vco_ld !== 1'b0) $display("FAIL midrst_ld: got %b expected 0", vco_ld);
      else pass_cnt++;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      stb_q.delete();
      send(64'h0085_003C, 32, 1'b1);
      model_commit(64'h0085_003C, 32);
      tick(2);
      total++;
      if (reg4 !== exp_regs[4] || stb_q.size() != 1) $display("FAIL midrst_r4: got %h with %0d pulses expected %h with 1", reg4, stb_q.size(), exp_regs[4]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [6];
      words[0] = 32'h0058_0005; words[1] = 32'h0085_003C; words[2] = 32'h0000_04B3;
      words[3] = 32'h0000_4E42; words[4] = 32'h0800_8011; words[5] = 32'h0035_8000;
      stb_q.delete();
      for (int f = 0; f < 6; f++) begin
         send(64'(words[f]), 32, 1'b1);
         model_commit(64'(words[f]), 32);
      end
      tick(2);
      total++;
      if (stb_q.size() != 6) $display("FAIL b2b_count: got %0d pulses expected 6", stb_q.size());
      else pass_cnt++;
      for (int f = 0; f < 6 && f < stb_q.size(); f++) begin
         total++;
         if (stb_q[f] !== 3'(5 - f)) $display("FAIL b2b_addr%0d: got %0d expected %0d", f, stb_q[f], 5 - f);
         else pass_cnt++;
      end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (dut_regs[i] !== exp_regs[i]) $display("FAIL b2b_reg%0d: got %h expected %h", i, dut_regs[i], exp_regs[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [63:0] w;
      int n, r, fe0;
      bit ok;
      for (int f = 0; f < 12; f++) begin
         w = {$urandom, $urandom};
         r = $urandom_range(0, 9);
         n = r < 6 ? 32 : r == 6 ? 31 : r == 7 ? 33 : r == 8 ? 40 : 0;
         ok = model_ok(w, n);
         fe0 = fe_cnt;
         stb_q.delete();
         send(w, n, 1'b1);
         model_commit(w, n);
         tick(2);
         total++;
         if (stb_q.size() != int'(ok) || fe_cnt - fe0 != int'(!ok)) $display("FAIL rand%0d_events: got stb=%0d fe=%0d expected stb=%0d fe=%0d (n=%0d w=%h)", f, stb_q.size(), fe_cnt - fe0, ok, !ok, n, w);
         else pass_cnt++;
         if (ok && stb_q.size() == 1) begin
            total++;
            if (stb_q[0] !== w[2:0]) $display("FAIL rand%0d_addr: got %0d expected %0d", f, stb_q[0], w[2:0]);
            else pass_cnt++;
         end
         for (int i = 0; i < 6; i++) begin
            total++;
            if (dut_regs[i] !== exp_regs[i]) $display("FAIL rand%0d_reg%0d: got %h expected %h", f, i, dut_regs[i], exp_regs[i]);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_lock();
      test_frame_err();
      test_power_down();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/adf4351_spi_model.md
Name: adf4351_spi_model

Overview:
- Synthesizable model of the ADF4351 3-wire serial interface and register file: the receive end of the PLL programming link.
- Oversamples vco_clk/vco_data/vco_le with clk_50, shifts in 32-bit words MSB first, and commits each word on LE rising to R0..R5, selected by control bits [2:0].
- Models lock detect on vco_ld.
- Used in benches opposite the PLL driver and as a loop-back self-check target on the board.

Parameters:
- LOCK_CYCLES, 5000: clk_50 cycles from the last R0/R1/R4 commit until vco_ld asserts (100 us).
- RST_ZERO, 0: if 1, all register data bits reset to 0; if 0, Rn resets to 32'h0 | n, so its control bits equal its address.

Ports:
- clk_50     in   1   system clock, 50 MHz
- rst_n      in   1   asynchronous active-low reset
- vco_clk    in   1   serial clock from driver, asynchronous to clk_50
- vco_data   in   1   serial data, sampled on vco_clk rising
- vco_le     in   1   load enable; rising edge commits the shift register
- vco_ce     in   1   chip enable; low = powered down
- vco_ld     out  1   lock detect, high = locked
- reg0..reg5 out  32  committed register images, including control bits [2:0]
- wr_stb     out  1   one-cycle pulse on each successful commit
- wr_addr    out  3   address of the last commit, valid with wr_stb
- frame_err  out  1   one-cycle pulse on a bad LE event (short/long frame or address 6/7)

Behaviour:
- Reset: asynchronous, active-low, clocked by clk_50.
  - Outputs: vco_ld=0, wr_stb=0, wr_addr=0, frame_err=0, regN per RST_ZERO.
  - Internal: shift register=0, bit_cnt=0, r0_seen=0, lock counter=0.
- Input conditioning:
  - vco_clk, vco_data, vco_le, vco_ce each pass a 2-FF synchronizer.
  - Edge detect compares the synchronizer output with a 1-cycle delayed copy.
  - Input timing requirement: vco_clk high and low ≥ 3 clk_50 periods; data setup/hold around vco_clk rising ≥ 2 clk_50 periods.
- Shift:
  - On synchronized vco_clk rising while le_s=0: shreg <= {shreg[30:0], data_s}; bit_cnt increments and saturates at 33.
  - vco_clk edges while le_s=1 are ignored.
- Commit, on synchronized vco_le rising:
  - bit_cnt==32 and shreg[2:0]<=5: reg[shreg[2:0]] <= shreg; wr_stb=1; wr_addr=shreg[2:0].
  - bit_cnt==32 and shreg[2:0] in {6,7}: no write, frame_err=1.
  - bit_cnt!=32 (including 0 and saturated 33): no write, frame_err=1.
  - bit_cnt clears to 0 in all three cases.
  - Latency: the update is visible on the 3rd clk_50 rising edge, counting the first edge that samples vco_le=1 as edge 1.
- Simultaneous vco_clk rise and vco_le rise in the same synchronized cycle: LE wins, the clock edge is dropped, and the commit uses the pre-existing shreg/bit_cnt.
- vco_ce low:
  - Register file and shifting keep working.
  - vco_ld forced 0 and the lock counter held at 0.
- Lock FSM, three states:
  - UNLOCKED: ld=0. Go to COUNTING when r0_seen=1 and ce_s=1.
  - COUNTING: ld=0, counter increments each cycle; at LOCK_CYCLES-1 go to LOCKED.
  - LOCKED: ld=1.
  - Any commit to R0, R1 or R4 (the commit to R0 also sets r0_seen) moves the FSM to COUNTING from any state, with the counter zeroed. Commits to R2, R3, R5 do not affect lock.
  - ce_s=0 moves the FSM to UNLOCKED from any state. When ce_s returns high it re-enters COUNTING (given r0_seen=1).
  - Commit and ce_s=0 in the same cycle: ce wins.
- Reset mid-frame or mid-count: everything returns to reset values immediately (asynchronous assert); deassertion is synchronous to clk_50.

Decomposition:
- Package adf4351_pkg holds:
  - ADF_WORD_W=32, ADF_NUM_REGS=6, ADF_CTRL_W=3.
  - Address constants ADF_R0..ADF_R5.
  - Lock state encoding LK_UNLOCKED/LK_COUNTING/LK_LOCKED.
- One sub-module, adf_sync_edge: per input, a 2-FF synchronizer plus rise detector, outputs level and rise pulse; instantiated 4 times.
- Shift/commit logic and lock FSM stay in the top module.

Test Plan:
- Single write: reset, send 32'h0058_0005 at 5 MHz, pulse LE -> reg5=32'h0058_0005, wr_stb one cycle with wr_addr=5, vco_ld stays 0, other regs at reset values.
- Lock: ce=1, write R0=32'h0035_8000 -> vco_ld rises exactly LOCK_CYCLES cycles after wr_stb. Then write R2=32'h0000_4E42 -> vco_ld stays 1. Then write R1=32'h0800_8011 -> vco_ld drops the next cycle and re-asserts after LOCK_CYCLES.
- Frame errors: send 31 bits then LE -> frame_err pulse, no register changes. Send 40 bits then LE -> frame_err pulse. Send full word 32'h0000_0006 -> frame_err pulse, wr_stb stays 0.
- Power-down: with lock held, drive ce=0 -> vco_ld=0 within 3 cycles. Write R3=32'h0000_04B3 while ce=0 -> reg3 updates. Raise ce -> vco_ld=1 after LOCK_CYCLES.
- Reset mid-frame: assert rst_n low after 16 bits -> all regs back to reset values. Release, send full R4=32'h0085_003C -> reg4 correct (no residue from the partial frame).
- Back-to-back: write R5..R0 with LE gaps of 3 clk_50 cycles -> six wr_stb pulses in order with addresses 5..0, all regs match the sent words.
